door_lock_ctrl: RTL
===================

# door_lock_ctrl

Keypad-driven lock controller that sits directly downstream of the random password generator (RPG). It requests a fresh 32-bit password from RPG via `keyEnable` and latches RPG's `newPass`. It then collects eight 4-bit keypad digits and compares them against the stored password. It drives `unlockDoor` back into RPG and the door actuator, so every successful unlock consumes the password and triggers a re-key (one-time password).

## Interface
Parameters:
- `OPEN_CYCLES`, 16: cycles `unlockDoor` stays high after a match (≥1).
- `LOCKOUT_CYCLES`, 64: cycles keypad is ignored after too many failures (≥1).
- `MAX_TRIES`, 3: consecutive failures that trigger lockout (1..7).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `newPass`  in  32  password from RPG, valid the cycle after `keyEnable` pulse and held.
- `digit_valid`  in  1  one-cycle strobe: `digit` carries a key press.
- `digit`  in  4  key value, 0x0–0xF.
- `enter`  in  1  one-cycle strobe: submit entered digits.
- `clear`  in  1  one-cycle strobe: discard entered digits.
- `keyEnable`  out  1  one-cycle request to RPG for a new password.
- `unlockDoor`  out  1  door open window.
- `attempt_fail`  out  1  one-cycle pulse on a rejected `enter`.
- `locked_out`  out  1  high during lockout.
- `digit_count`  out  4  digits currently buffered, 0..8.

## Operation
- States: REKEY, LOAD, IDLE, OPEN, LOCKOUT.
- REKEY: `keyEnable`=1 for exactly one cycle → LOAD.
- LOAD: `pass_reg` ← `newPass`; entry buffer and `digit_count` cleared → IDLE.
- IDLE accepts key presses:
  - Each `digit_valid` shifts `digit` into the low nibble of a 32-bit entry register: `entry = {entry[27:0], digit}`. The first digit ends up in bits [31:28] after eight presses.
  - `digit_count` increments, saturating at 8. A 9th or later digit is dropped; entry is unchanged.
  - `clear`: entry←0, `digit_count`←0; the failure counter is not touched.
- IDLE on `enter`:
  - Match means `digit_count`==8 and entry==`pass_reg`. On a match: failure counter←0 → OPEN.
  - Otherwise: `attempt_fail` pulses, failure counter increments, entry and count clear. If the counter reaches `MAX_TRIES` → LOCKOUT, else stay IDLE.
- Same-cycle priority in IDLE: `clear` > `enter` > `digit_valid`. Lower-priority strobes in that cycle are dropped.
- OPEN: `unlockDoor`=1 for `OPEN_CYCLES` cycles → REKEY.
- LOCKOUT: `locked_out`=1 for `LOCKOUT_CYCLES` cycles; failure counter←0 → REKEY.
- In REKEY, LOAD, OPEN and LOCKOUT, `digit_valid`/`enter`/`clear` are ignored.
- Failure counter is 3 bits; it never exceeds `MAX_TRIES`.

## Timing
- Reset values: `keyEnable`=0, `unlockDoor`=0, `attempt_fail`=0, `locked_out`=0, `digit_count`=0, `pass_reg`=0, entry=0, failure counter=0, state=REKEY.
- Cycle numbering is relative to the first rising edge with `rst` low (cycle 0). `keyEnable`=1 in cycle 0; `newPass` latched at end of cycle 1; IDLE from cycle 2.
- `rst` asserted in any state, including mid-OPEN or mid-LOCKOUT: all outputs take reset values on the next edge. `unlockDoor` drops immediately.
- If `enter` is sampled at cycle t:
  - Match: `unlockDoor`=1 in cycles t+1 … t+`OPEN_CYCLES`; `keyEnable`=1 in cycle t+`OPEN_CYCLES`+1; IDLE again at t+`OPEN_CYCLES`+3.
  - Failure: `attempt_fail`=1 in cycle t+1.
  - Lockout: `locked_out`=1 in cycles t+1 … t+`LOCKOUT_CYCLES`, then REKEY.
- `digit_count` updates the cycle after the strobe.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `DOOR_LOCK_LOCKOUT_EN` defined: failure counter, LOCKOUT state and `locked_out` behave as above.
- Not defined: no failure counter and no LOCKOUT state. Failures only pulse `attempt_fail` and clear entry, staying in IDLE. `locked_out` is tied 0, and `MAX_TRIES`/`LOCKOUT_CYCLES` are unused.

## Test plan
- Reset then RPG model returns `newPass`=0x1234ABCD → `keyEnable` pulses in cycle 0 only. Keying 1,2,3,4,A,B,C,D then `enter` gives `unlockDoor` high for exactly 16 cycles, then `keyEnable` pulses once.
- Stored 0x1234ABCD; key 1,2,3,4,A,B,C,E + `enter` → `attempt_fail` one pulse, `unlockDoor` stays 0, `digit_count` returns to 0.
- Key seven digits + `enter` → fail. Key ten digits (first eight correct) + `enter` → unlock, because the extra digits are dropped.
- Three wrong entries (macro defined) → `locked_out` high 64 cycles; digits ignored meanwhile; then REKEY. Without the macro: no lockout, 4th correct entry unlocks.
- `clear` and `enter` in the same cycle after eight correct digits → no unlock, no `attempt_fail`, `digit_count`=0.
- `rst` asserted in the 5th cycle of OPEN → `unlockDoor` 0 next cycle; `keyEnable` pulses the first cycle after `rst` releases.

Source files
------------

// File: rtl/door_lock_ctrl_if.sv
// Keypad/RPG bus for door_lock_ctrl. The master drives the keypad strobes and the
// RPG password; the slave (the lock controller) drives the registered status outputs.
interface door_lock_ctrl_if;
  // No valid/ready pairs on this bus: digit_valid, enter and clear are one-cycle
  // strobes that are always accepted (or dropped) on the edge that samples them,
  // and newPass is held by RPG from the cycle after a keyEnable pulse.
  logic [31:0] newPass;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic        keyEnable;
  logic        unlockDoor;
  logic        attempt_fail;
  logic        locked_out;
  logic [3:0]  digit_count;

  modport master (
    output newPass, digit_valid, digit, enter, clear,
    input  keyEnable, unlockDoor, attempt_fail, locked_out, digit_count
  );

  modport slave (
    input  newPass, digit_valid, digit, enter, clear,
    output keyEnable, unlockDoor, attempt_fail, locked_out, digit_count
  );
endinterface

// File: rtl/door_lock_ctrl.sv
// One-time-password keypad lock: re-keys from RPG, buffers eight digits, opens on match.
// Define DOOR_LOCK_LOCKOUT_EN to add the failure counter and LOCKOUT state.
module door_lock_ctrl #(
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int MAX_TRIES      = 3
) (
  input  logic             clk,
  input  logic             rst,
  door_lock_ctrl_if.slave  bus,
  output logic [2:0]       dbg_state
);

  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  if (OPEN_CYCLES < 1 || LOCKOUT_CYCLES < 1 || MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_bad_param
    $error("door_lock_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_REKEY   = 3'd0,
    S_LOAD    = 3'd1,
    S_IDLE    = 3'd2,
    S_OPEN    = 3'd3
`ifdef DOOR_LOCK_LOCKOUT_EN
    , S_LOCKOUT = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     pass_q, pass_d;
  logic [31:0]     entry_q, entry_d;
  logic [3:0]      count_q, count_d;
  logic            key_en_q, key_en_d;
  logic            unlock_q, unlock_d;
  logic            fail_pulse_q, fail_pulse_d;
`ifdef DOOR_LOCK_LOCKOUT_EN
  logic [2:0]      fails_q, fails_d;
  logic            locked_q, locked_d;
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pass_d       = pass_q;
    entry_d      = entry_q;
    count_d      = count_q;
    key_en_d     = 1'b0;
    unlock_d     = 1'b0;
    fail_pulse_d = 1'b0;
`ifdef DOOR_LOCK_LOCKOUT_EN
    fails_d      = fails_q;
    locked_d     = 1'b0;
`endif
    unique case (state_q)
      S_REKEY: begin
        key_en_d = 1'b1;
        state_d  = S_LOAD;
      end
      // First LOAD cycle overlaps the keyEnable pulse; RPG's word is valid one cycle later.
      S_LOAD: begin
        if (!key_en_q) begin
          pass_d  = bus.newPass;
          entry_d = '0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.clear) begin
          entry_d = '0;
          count_d = '0;
        end else if (bus.enter) begin
          entry_d = '0;
          count_d = '0;
          if (count_q == 4'd8 && entry_q == pass_q) begin
            unlock_d = 1'b1;
            timer_d  = TW'(OPEN_CYCLES - 1);
            state_d  = S_OPEN;
`ifdef DOOR_LOCK_LOCKOUT_EN
            fails_d  = '0;
`endif
          end else begin
            fail_pulse_d = 1'b1;
`ifdef DOOR_LOCK_LOCKOUT_EN
            fails_d = fails_q + 3'd1;
            if (fails_q + 3'd1 == 3'(MAX_TRIES)) begin
              locked_d = 1'b1;
              timer_d  = TW'(LOCKOUT_CYCLES - 1);
              state_d  = S_LOCKOUT;
            end
`endif
          end
        end else if (bus.digit_valid && count_q < 4'd8) begin
          entry_d = {entry_q[27:0], bus.digit};
          count_d = count_q + 4'd1;
        end
      end
      // Leaving OPEN/LOCKOUT raises keyEnable directly, so the REKEY pulse is not delayed.
      S_OPEN: begin
        if (timer_q == '0) begin
          key_en_d = 1'b1;
          state_d  = S_LOAD;
        end else begin
          timer_d  = timer_q - TW'(1);
          unlock_d = 1'b1;
        end
      end
`ifdef DOOR_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fails_d  = '0;
          key_en_d = 1'b1;
          state_d  = S_LOAD;
        end else begin
          timer_d  = timer_q - TW'(1);
          locked_d = 1'b1;
        end
      end
`endif
      default: state_d = S_REKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REKEY;
      timer_q      <= '0;
      pass_q       <= '0;
      entry_q      <= '0;
      count_q      <= '0;
      key_en_q     <= 1'b0;
      unlock_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fails_q      <= '0;
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pass_q       <= pass_d;
      entry_q      <= entry_d;
      count_q      <= count_d;
      key_en_q     <= key_en_d;
      unlock_q     <= unlock_d;
      fail_pulse_q <= fail_pulse_d;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fails_q      <= fails_d;
      locked_q     <= locked_d;
`endif
    end
  end

  assign bus.keyEnable    = key_en_q;
  assign bus.unlockDoor   = unlock_q;
  assign bus.attempt_fail = fail_pulse_q;
  assign bus.digit_count  = count_q;
`ifdef DOOR_LOCK_LOCKOUT_EN
  assign bus.locked_out   = locked_q;
`else
  assign bus.locked_out   = 1'b0;
`endif
  assign dbg_state        = state_q;

endmodule
